// File: rtl/cv32e40p_rf_recovery_seq.sv
// Register-file recovery sequencer: quiesces the core, then replays a checkpoint
// into the RF write ports two registers (even/odd pair) per cycle.
module cv32e40p_rf_recovery_seq #(
  parameter int NUM_REGS = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        ckpt_valid_i,
  input  logic        quiesce_i,
  output logic        ckpt_req_o,
  input  logic        ckpt_gnt_i,
  output logic [5:0]  ckpt_raddr_a_o,
  output logic [5:0]  ckpt_raddr_b_o,
  input  logic [31:0] ckpt_rdata_a_i,
  input  logic [31:0] ckpt_rdata_b_i,
  output logic        recover_o,
  output logic [5:0]  regfile_waddr_a_o,
  output logic [31:0] regfile_wdata_a_o,
  output logic        regfile_we_a_o,
  output logic [5:0]  regfile_waddr_b_o,
  output logic [31:0] regfile_wdata_b_o,
  output logic        regfile_we_b_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);

  //  state   | meaning
  //  S_IDLE  | waiting for start_i; checks ckpt_valid_i
  //  S_HALT  | recover asserted, waiting for the core to quiesce
  //  S_READ  | requesting register pairs from checkpoint storage
  //  S_FLUSH | last pair's read data is being written
  //  S_DONE  | one-cycle completion pulse

  localparam int NPAIRS = NUM_REGS / 2;
  localparam int CNT_W  = $clog2(NPAIRS);
  localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(NPAIRS - 1);

  if (NUM_REGS != 32 && NUM_REGS != 64) begin : g_bad_num_regs
    $error("cv32e40p_rf_recovery_seq: NUM_REGS must be 32 or 64");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_READ,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pend;
  logic             r_error;
  logic [5:0]       r_waddr_a;
  logic [5:0]       r_waddr_b;

  logic             w_recover;
  logic             w_req;
  logic             w_done;
  logic             w_grant;
  logic [5:0]       w_raddr_a;
  logic [5:0]       w_raddr_b;

  assign w_raddr_a = 6'({r_cnt, 1'b0});
  assign w_raddr_b = 6'({r_cnt, 1'b1});
  assign w_grant   = (r_state == S_READ) && ckpt_gnt_i;

  always_comb begin
    w_next    = r_state;
    w_recover = 1'b0;
    w_req     = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i && ckpt_valid_i) w_next = S_HALT;
      end
      S_HALT: begin
        w_recover = 1'b1;
        if (quiesce_i) w_next = S_READ;
      end
      S_READ: begin
        w_recover = 1'b1;
        w_req     = 1'b1;
        if (ckpt_gnt_i && (r_cnt == LAST_PAIR)) w_next = S_FLUSH;
      end
      S_FLUSH: begin
        w_recover = 1'b1;
        w_next    = S_DONE;
      end
      S_DONE: begin
        w_recover = 1'b1;
        w_done    = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt     <= '0;
      r_pend    <= 1'b0;
      r_error   <= 1'b0;
      r_waddr_a <= '0;
      r_waddr_b <= '0;
    end else begin
      r_pend  <= w_grant;
      r_error <= (r_state == S_IDLE) && start_i && !ckpt_valid_i;
      if ((r_state == S_HALT) && quiesce_i) begin
        r_cnt <= '0;
      end else if (w_grant) begin
        r_cnt <= (r_cnt == LAST_PAIR) ? '0 : r_cnt + 1'b1;
      end
      if (w_grant) begin
        r_waddr_a <= w_raddr_a;
        r_waddr_b <= w_raddr_b;
      end
    end
  end

  // Addresses and data are gated so the bus stays quiet outside a transfer.
  assign ckpt_req_o        = w_req;
  assign ckpt_raddr_a_o    = w_req ? w_raddr_a : 6'd0;
  assign ckpt_raddr_b_o    = w_req ? w_raddr_b : 6'd0;
  assign recover_o         = w_recover;
  assign regfile_waddr_a_o = r_waddr_a;
  assign regfile_waddr_b_o = r_waddr_b;
  assign regfile_wdata_a_o = r_pend ? ckpt_rdata_a_i : 32'd0;
  assign regfile_wdata_b_o = r_pend ? ckpt_rdata_b_i : 32'd0;
  assign regfile_we_b_o    = r_pend;
  assign regfile_we_a_o    = r_pend && (r_waddr_a != 6'd0);
  assign busy_o            = (r_state != S_IDLE);
  assign done_o            = w_done;
  assign error_o           = r_error;

endmodule
